// File: rtl/key_debounce_if.sv
// Push-button bus between the board keys and the key-handling logic.
// The design side takes the slave modport; the producer/observer takes master.
interface key_debounce_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] repeat_en;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_repeat;
  logic              key_any;

  modport slave (
    input  key_n, repeat_en,
    output key_level, key_press, key_release, key_repeat, key_any
  );

  modport master (
    output key_n, repeat_en,
    input  key_level, key_press, key_release, key_repeat, key_any
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key synchronizer, counter debouncer and auto-repeat FSM for the
// active-low push-buttons; emits clean levels plus press/release/repeat pulses.
module key_debounce #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic           clk,
  input  logic           rst,
  key_debounce_if.slave  bus
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  logic [N_KEYS-1:0] level_v;
  logic [N_KEYS-1:0] press_v;
  logic [N_KEYS-1:0] release_v;
  logic [N_KEYS-1:0] repeat_v;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic [1:0]       sync;
    logic             s;
    logic [CNT_W-1:0] dcnt;
    logic             stable;
    logic             press_q;
    logic             release_q;
    logic             accept;
    logic             press_flip;
    logic             release_flip;

    rep_state_t       state, state_nxt;
    logic [CNT_W-1:0] rcnt, rcnt_nxt;
    logic             repeat_q, repeat_nxt;

    // Synchronizer resets to the released level so no spurious press follows reset.
    // NOTE: every clocked register here uses <= so all flops see pre-edge values;
    // blocking assignments would let sync[1] capture the new sync[0] in one edge.
    always_ff @(posedge clk) begin
      if (rst) sync <= 2'b11;
      else     sync <= {sync[0], bus.key_n[i]};
    end

    assign s            = ~sync[1];
    assign accept       = (s != stable) && (dcnt == DB_LAST);
    assign press_flip   = accept && s;
    assign release_flip = accept && !s;

    always_ff @(posedge clk) begin
      if (rst) begin
        dcnt      <= '0;
        stable    <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= press_flip;
        release_q <= release_flip;
        if (s == stable) begin
          dcnt <= '0;
        end else if (accept) begin
          stable <= s;
          dcnt   <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end
    end

    // Release and a cleared enable both win over a coincident repeat tick.
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
      state_nxt  = state;
      rcnt_nxt   = rcnt;
      repeat_nxt = 1'b0;
      unique case (state)
        IDLE: begin
          if (press_flip && bus.repeat_en[i]) begin
            state_nxt = DELAY;
            rcnt_nxt  = '0;
          end
        end
        DELAY: begin
          if (release_flip || !bus.repeat_en[i]) begin
            state_nxt = IDLE;
            rcnt_nxt  = '0;
          end else if (rcnt == RD_LAST) begin
            state_nxt  = REPEAT;
            rcnt_nxt   = '0;
            repeat_nxt = 1'b1;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
        end
        REPEAT: begin
          if (release_flip || !bus.repeat_en[i]) begin
            state_nxt = IDLE;
            rcnt_nxt  = '0;
          end else if (rcnt == RR_LAST) begin
            rcnt_nxt   = '0;
            repeat_nxt = 1'b1;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state    <= IDLE;
        rcnt     <= '0;
        repeat_q <= 1'b0;
      end else begin
        state    <= state_nxt;
        rcnt     <= rcnt_nxt;
        repeat_q <= repeat_nxt;
      end
    end

    assign level_v[i]   = stable;
    assign press_v[i]   = press_q;
    assign release_v[i] = release_q;
    assign repeat_v[i]  = repeat_q;
  end

  assign bus.key_level   = level_v;
  assign bus.key_press   = press_v;
  assign bus.key_release = release_v;
  assign bus.key_repeat  = repeat_v;
  assign bus.key_any     = |level_v;

endmodule

// File: tb/tb_key_debounce.sv
// Randomized and directed bench for key_debounce: a window-based behavioural
// model pushes per-cycle expectations; a monitor pops and compares them.
module tb_key_debounce;

  localparam int NK   = 4;
  localparam int DC   = 4;
  localparam int RD   = 10;
  localparam int RR   = 3;
  localparam int HMAX = 8192;

  typedef struct packed {
    logic [NK-1:0] level;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [NK-1:0] rpt;
    logic          any;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  key_debounce_if #(.N_KEYS(NK)) bus ();

  key_debounce #(
    .N_KEYS(NK),
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR),
    .CNT_W(25)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: a change is accepted once the synchronized key has
  // differed from the accepted level on each of the last DC non-reset edges;
  // repeats fall at press + RD + k*RR while enable stays high and key is held.
  int            cyc = 0;
  logic [NK-1:0] raw_h [HMAX];
  logic [NK-1:0] s_h   [HMAX];
  bit            rst_h [HMAX];
  logic [NK-1:0] lvl = '0;
  bit            rep_act [NK];
  int            rep_t0  [NK];

  always @(posedge clk) begin
    exp_t          e;
    logic [NK-1:0] s;
    bit            acc;
    int            idx;
    int            dt;
    e.cyc = cyc;
    e.v   = '0;
    if (cyc >= HMAX) begin
      $display("FAIL model_history cycle %0d exceeds history size %0d", cyc, HMAX);
      $fatal(1, "history overflow");
    end
    raw_h[cyc] = ~bus.key_n;
    rst_h[cyc] = rst;
    if (rst) begin
      lvl = '0;
      s_h[cyc] = '0;
      for (int k = 0; k < NK; k++) rep_act[k] = 0;
    end else begin
      if (cyc < 2 || rst_h[cyc-1] || rst_h[cyc-2]) s = '0;
      else                                        s = raw_h[cyc-2];
      s_h[cyc] = s;
      for (int k = 0; k < NK; k++) begin
        acc = 1;
        for (int j = 0; j < DC; j++) begin
          idx = cyc - j;
          if (idx < 0)                    acc = 0;
          else if (rst_h[idx])            acc = 0;
          else if (s_h[idx][k] == lvl[k]) acc = 0;
        end
        if (acc) begin
          if (!lvl[k]) begin
            e.v.press[k] = 1'b1;
            if (bus.repeat_en[k]) begin
              rep_act[k] = 1;
              rep_t0[k]  = cyc;
            end
          end else begin
            e.v.rel[k] = 1'b1;
            rep_act[k] = 0;
          end
          lvl[k] = ~lvl[k];
        end else if (rep_act[k]) begin
          if (!bus.repeat_en[k]) begin
            rep_act[k] = 0;
          end else begin
            dt = cyc - rep_t0[k];
            if (dt == RD || (dt > RD && (dt - RD) % RR == 0)) e.v.rpt[k] = 1'b1;
          end
        end
      end
    end
    e.v.level = lvl;
    e.v.any   = |lvl;
    sb_q.push_back(e);
    cyc++;
  end

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    obs_t a;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = '{level: bus.key_level, press: bus.key_press, rel: bus.key_release,
            rpt: bus.key_repeat, any: bus.key_any};
      n_checks++;
      if (a !== e.v) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got lvl=%b prs=%b rel=%b rpt=%b any=%b, want lvl=%b prs=%b rel=%b rpt=%b any=%b",
                 e.cyc, a.level, a.press, a.rel, a.rpt, a.any,
                 e.v.level, e.v.press, e.v.rel, e.v.rpt, e.v.any);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    bus.key_n     = '1;
    bus.repeat_en = '0;
    step(3);
    rst = 1'b0;
    step(50);

    // Clean press and release on key 0.
    bus.key_n[0] = 1'b0; step(12);
    bus.key_n[0] = 1'b1; step(12);

    // Glitches on key 1 shorter than the debounce window, then a real press.
    repeat (5) begin
      bus.key_n[1] = 1'b0; step(3);
      bus.key_n[1] = 1'b1; step(3);
    end
    bus.key_n[1] = 1'b0; step(10);
    bus.key_n[1] = 1'b1; step(10);

    // Auto-repeat on key 2.
    bus.repeat_en[2] = 1'b1;
    bus.key_n[2] = 1'b0; step(30);
    bus.key_n[2] = 1'b1; step(15);

    // Key 3 held with repeat disabled; key 2 repeat cut by dropping enable.
    bus.key_n[3] = 1'b0; step(40);
    bus.key_n[3] = 1'b1; step(10);
    bus.key_n[2] = 1'b0; step(22);
    bus.repeat_en[2] = 1'b0; step(10);
    bus.key_n[2] = 1'b1; step(10);
    bus.repeat_en[2] = 1'b1;

    // Simultaneous press on keys 0 and 3, then reset during a repeat delay.
    bus.key_n[0] = 1'b0;
    bus.key_n[3] = 1'b0; step(10);
    bus.key_n = '1;      step(10);
    bus.key_n[2] = 1'b0; step(10);
    rst = 1'b1;
    bus.key_n[2] = 1'b1; step(2);
    rst = 1'b0;          step(20);

    // Randomized bouncing keys, enable changes and occasional resets.
    repeat (1500) begin
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 99) < 6) bus.key_n[k] = ~bus.key_n[k];
      if ($urandom_range(0, 199) == 0) bus.repeat_en = NK'($urandom);
      rst = ($urandom_range(0, 599) == 0);
      step(1);
    end
    rst       = 1'b0;
    bus.key_n = '1;
    step(12);
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    if (sb_q.size() > 1) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want at most 1", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
